vga_timing_receiver: RTL and testbench

Sink-side counterpart of the VGA timing generator. It samples an incoming h_sync/v_sync/DE stream at the pixel rate and reconstructs x/y pixel coordinates. It also measures line and frame periods, checks them against nominal 640x480 timing, and reports lock status. It sits at the input of the capture/processing path and feeds coordinates and strobes to downstream pixel logic.

---
 rtl/vga_timing_receiver.sv | 219 +++++++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_receiver.sv
// Sink-side VGA timing recovery: rebuilds x/y coordinates from sampled sync/DE,
// measures line and frame periods and tracks lock against the nominal raster.
module vga_timing_receiver #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic       de_in,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel,
    output logic       de_out,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] h_period,
    output logic [9:0] v_period,
    output logic       locked,
    output logic       timing_error
);

    localparam int CNT_W = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
    localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [9:0] MEAS_MAX   = 10'h3FF;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {UNLOCKED, SEARCH, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic             h_seen_q, h_seen_d;
    logic             armed_q, armed_d;
    logic             frame_ok_q, frame_ok_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [9:0]       h_meas_q, h_meas_d, v_meas_q, v_meas_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [9:0]       h_period_q, h_period_d, v_period_q, v_period_d;
    logic             de_out_q, de_out_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             locked_q, locked_d;
    logic             terr_q, terr_d;

    logic h_fall, v_fall, de_rise, de_fall;
    logic err_h, err_de, err_v, err_any, lock_reached;

    assign h_fall  = hs_q & ~h_sync_in;
    assign v_fall  = vs_q & ~v_sync_in;
    assign de_rise = ~de_q & de_in;
    assign de_fall = de_q & ~de_in;

    // Violations are only meaningful once h_seen has a full line behind it.
    assign err_h   = h_fall & h_seen_q & ((h_meas_q + 10'd1) != H_TOTAL_C);
    assign err_de  = de_fall & ((x_q + 10'd1) != H_ACTIVE_C);
    assign err_v   = v_fall & ((v_meas_q != V_TOTAL_C) | (y_q != V_ACTIVE_C));
    assign err_any = err_h | err_de | err_v;
    assign lock_reached = (int'(good_cnt_q) + 1) >= LOCK_FRAMES;

    always_comb begin
        state_d       = state_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        de_d          = de_q;
        h_seen_d      = h_seen_q;
        armed_d       = armed_q;
        frame_ok_d    = frame_ok_q;
        good_cnt_d    = good_cnt_q;
        h_meas_d      = h_meas_q;
        v_meas_d      = v_meas_q;
        x_d           = x_q;
        y_d           = y_q;
        de_out_d      = de_out_q;
        h_period_d    = h_period_q;
        v_period_d    = v_period_q;
        locked_d      = locked_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        terr_d        = 1'b0;

        if (pix_en) begin
            hs_d     = h_sync_in;
            vs_d     = v_sync_in;
            de_d     = de_in;
            de_out_d = de_in;

            if (h_fall) begin
                h_meas_d = '0;
                h_seen_d = 1'b1;
                if (h_seen_q) h_period_d = h_meas_q + 10'd1;
            end else if (h_meas_q != MEAS_MAX) begin
                h_meas_d = h_meas_q + 10'd1;
            end

            // A line starting on the frame's v_fall already belongs to the new frame.
            if (v_fall) begin
                v_period_d = v_meas_q;
                v_meas_d   = h_fall ? 10'd1 : 10'd0;
            end else if (h_fall) begin
                v_meas_d = v_meas_q + 10'd1;
            end

            if (de_rise)            x_d = '0;
            else if (de_in && de_q) x_d = x_q + 10'd1;

            if (v_fall)       y_d = '0;
            else if (de_fall) y_d = y_q + 10'd1;

            line_start_d  = de_rise;
            frame_start_d = de_rise & armed_q;
            if (v_fall)             armed_d = 1'b1;
            else if (frame_start_d) armed_d = 1'b0;

            case (state_q)
                UNLOCKED: begin
                    if (v_fall) begin
                        state_d    = SEARCH;
                        good_cnt_d = '0;
                        frame_ok_d = 1'b1;
                    end
                end
                SEARCH: begin
                    terr_d = err_any;
                    if (v_fall) begin
                        frame_ok_d = 1'b1;
                        if (frame_ok_q && !err_any) begin
                            if (lock_reached) begin
                                state_d    = LOCKED;
                                locked_d   = 1'b1;
                                good_cnt_d = LOCK_CNT;
                            end else begin
                                good_cnt_d = good_cnt_q + CNT_ONE;
                            end
                        end else begin
                            good_cnt_d = '0;
                        end
                    end else if (err_any) begin
                        frame_ok_d = 1'b0;
                    end
                end
                LOCKED: begin
                    terr_d = err_any;
                    if (err_any) begin
                        state_d    = SEARCH;
                        locked_d   = 1'b0;
                        good_cnt_d = '0;
                        frame_ok_d = v_fall;
                    end else if (v_fall) begin
                        frame_ok_d = 1'b1;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= UNLOCKED;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            de_q          <= 1'b0;
            h_seen_q      <= 1'b0;
            armed_q       <= 1'b0;
            frame_ok_q    <= 1'b0;
            good_cnt_q    <= '0;
            h_meas_q      <= '0;
            v_meas_q      <= '0;
            x_q           <= '0;
            y_q           <= '0;
            de_out_q      <= 1'b0;
            h_period_q    <= '0;
            v_period_q    <= '0;
            locked_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            terr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            h_seen_q      <= h_seen_d;
            armed_q       <= armed_d;
            frame_ok_q    <= frame_ok_d;
            good_cnt_q    <= good_cnt_d;
            h_meas_q      <= h_meas_d;
            v_meas_q      <= v_meas_d;
            x_q           <= x_d;
            y_q           <= y_d;
            de_out_q      <= de_out_d;
            h_period_q    <= h_period_d;
            v_period_q    <= v_period_d;
            locked_q      <= locked_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            terr_q        <= terr_d;
        end
    end

    assign x_pixel      = x_q;
    assign y_pixel      = y_q;
    assign de_out       = de_out_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign h_period     = h_period_q;
    assign v_period     = v_period_q;
    assign locked       = locked_q;
    assign timing_error = terr_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Scoreboard bench for vga_timing_receiver on a scaled-down raster (16x8 active,
// 24x12 total) so that many frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_receiver;

    localparam int HA  = 16;
    localparam int HT  = 24;
    localparam int VA  = 8;
    localparam int VT  = 12;
    localparam int HS0 = 18;
    localparam int HS1 = 21;
    localparam int VS0 = 9;
    localparam int VS1 = 11;

    localparam int EV_TE = 0;
    localparam int EV_LK = 1;
    localparam int EV_LS = 2;
    localparam int EV_FS = 3;
    localparam int EV_DF = 4;
    localparam int EV_PR = 5;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
        int d;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       pix_en;
    logic       h_sync_in;
    logic       v_sync_in;
    logic       de_in;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
    logic       de_out;
    logic       line_start;
    logic       frame_start;
    logic [9:0] h_period;
    logic [9:0] v_period;
    logic       locked;
    logic       timing_error;

    logic probe;
    logic done;
    ev_t  exp_q[$];
    int   n_tests;
    int   n_fail;
    logic prev_lk;
    logic prev_de;
    bit   fin;

    vga_timing_receiver #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .de_in(de_in),
        .x_pixel(x_pixel), .y_pixel(y_pixel), .de_out(de_out),
        .line_start(line_start), .frame_start(frame_start),
        .h_period(h_period), .v_period(v_period),
        .locked(locked), .timing_error(timing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        if (exp >= 0) begin
            n_tests++;
            if (act != exp) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", name, act, exp);
            end
        end
    endtask

    task automatic take(input int kind, output bit ok, output ev_t e);
        n_tests++;
        ok = 1'b0;
        e  = '{kind: -1, a: -1, b: -1, c: -1, d: -1};
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event_%0d: observed with no event expected", kind);
        end else if (exp_q[0].kind != kind) begin
            n_fail++;
            $display("FAIL event_%0d: observed while event %0d was expected", kind, exp_q[0].kind);
        end else begin
            e  = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        prev_lk = 1'b0;
        prev_de = 1'b0;
        fin     = 1'b0;
    end

    always @(posedge clk) begin
        bit  ok;
        ev_t e;
        #1;
        if (reset) begin
            chk("rst_x", int'(x_pixel), 0);
            chk("rst_y", int'(y_pixel), 0);
            chk("rst_de_out", int'(de_out), 0);
            chk("rst_line_start", int'(line_start), 0);
            chk("rst_frame_start", int'(frame_start), 0);
            chk("rst_h_period", int'(h_period), 0);
            chk("rst_v_period", int'(v_period), 0);
            chk("rst_locked", int'(locked), 0);
            chk("rst_timing_error", int'(timing_error), 0);
            prev_lk = 1'b0;
            prev_de = 1'b0;
        end else begin
            if (timing_error) take(EV_TE, ok, e);
            if (locked != prev_lk) begin
                take(EV_LK, ok, e);
                if (ok) chk("locked_edge", int'(locked), e.a);
            end
            if (line_start) begin
                take(EV_LS, ok, e);
                if (ok) begin
                    chk("ls_x", int'(x_pixel), 0);
                    chk("ls_y", int'(y_pixel), e.a);
                end
            end
            if (frame_start) begin
                take(EV_FS, ok, e);
                if (ok) begin
                    chk("fs_x", int'(x_pixel), 0);
                    chk("fs_y", int'(y_pixel), 0);
                    chk("fs_h_period", int'(h_period), e.a);
                    chk("fs_v_period", int'(v_period), e.b);
                end
            end
            if (prev_de && !de_out) begin
                take(EV_DF, ok, e);
                if (ok) begin
                    chk("de_fall_x", int'(x_pixel), e.a);
                    chk("de_fall_y", int'(y_pixel), e.b);
                end
            end
            if (probe) begin
                take(EV_PR, ok, e);
                if (ok) begin
                    chk("hold_x", int'(x_pixel), e.a);
                    chk("hold_y", int'(y_pixel), e.b);
                    chk("hold_h_period", int'(h_period), e.c);
                    chk("hold_v_period", int'(v_period), e.d);
                    chk("hold_de_out", int'(de_out), 1);
                    chk("hold_locked", int'(locked), 1);
                end
            end
            prev_lk = locked;
            prev_de = de_out;
        end
        if (done && !fin) begin
            fin = 1'b1;
            chk("pending_events", exp_q.size(), 0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    function automatic void push(input int k, input int a, input int b, input int c, input int d);
        exp_q.push_back('{kind: k, a: a, b: b, c: c, d: d});
    endfunction

    task automatic send(input logic h, input logic v, input logic d);
        @(negedge clk);
        h_sync_in = h;
        v_sync_in = v;
        de_in     = d;
        pix_en    = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pause_probe(input int xv, input int yv);
        push(EV_PR, xv, yv, HT, VT);
        @(negedge clk);
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;
        repeat (47) @(negedge clk);
        push(EV_PR, xv, yv, HT, VT);
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;
    endtask

    // One raster frame with optional faults; expected events are pushed per sample.
    task automatic run_frame(input bit exp_fs, input int fs_hp, input int fs_vp,
                             input bit lock_rise, input int short_h, input int short_de,
                             input int pause_l, input int rst_l);
        bit   yk;
        int   dlen;
        logic h, v, d;
        yk = 1'b1;
        for (int l = 0; l < VT; l++) begin
            for (int s = 0; s < HT; s++) begin
                if (l == short_h && s == HT - 1) continue;
                if (l == rst_l && s == 22) begin
                    pulse_reset();
                    yk = 1'b0;
                end
                h    = !((s >= HS0) && (s < HS1));
                v    = !((l >= VS0) && (l < VS1));
                dlen = (l == short_de) ? HA - 1 : HA;
                d    = (l < VA) && (s < dlen);
                if (l == VS0 && s == 0 && lock_rise) push(EV_LK, 1, 0, 0, 0);
                if (short_h >= 0 && l == short_h + 1 && s == HS0) begin
                    push(EV_TE, 0, 0, 0, 0);
                    push(EV_LK, 0, 0, 0, 0);
                end
                if (d && s == 0) begin
                    push(EV_LS, yk ? l : -1, 0, 0, 0);
                    if (exp_fs && l == 0) push(EV_FS, fs_hp, fs_vp, 0, 0);
                end
                if (l < VA && s == dlen) begin
                    if (l == short_de) begin
                        push(EV_TE, 0, 0, 0, 0);
                        push(EV_LK, 0, 0, 0, 0);
                    end
                    push(EV_DF, dlen - 1, yk ? l + 1 : -1, 0, 0);
                end
                send(h, v, d);
                if (l == pause_l && s == 5) pause_probe(5, l);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        pix_en    = 1'b0;
        h_sync_in = 1'b1;
        v_sync_in = 1'b1;
        de_in     = 1'b0;
        probe     = 1'b0;
        done      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        //        fs  hp  vp lock shH shDE pause rst
        run_frame(0, -1, -1, 0, -1, -1, -1, -1);
        run_frame(1, HT, VS0, 0, -1, -1, -1, -1);
        run_frame(1, HT, VT, 1, -1, -1, -1, -1);
        run_frame(1, HT, VT, 0, -1, -1, 2, -1);
        run_frame(1, HT, VT, 0, 4, -1, -1, -1);
        run_frame(1, HT, VT, 0, -1, -1, -1, -1);
        run_frame(1, HT, VT, 1, -1, -1, -1, -1);
        run_frame(1, HT, VT, 0, -1, 5, -1, -1);
        run_frame(1, HT, VT, 0, -1, -1, -1, -1);
        run_frame(1, HT, VT, 1, -1, -1, -1, -1);
        run_frame(1, HT, VT, 0, -1, -1, -1, 3);
        run_frame(1, HT, 5, 0, -1, -1, -1, -1);
        run_frame(1, HT, VT, 1, -1, -1, -1, -1);

        repeat (4) @(negedge clk);
        done = 1'b1;
    end

endmodule
